turn_ctrl: RTL and testbench

Turn and fire sequencer for the two-tank artillery game. Once per frame it samples the keyboard and does four things: it lets the active player set aim direction and launch power, issues a single-frame `shoot` pulse to the bullet block, and watches the flight until the bullet hits or lands. It then applies damage and hands the turn to the other player. It sits directly upstream of the bullet block and drives that block's `shoot`, `Direction`, `y_component` and `currentTank` inputs, and it consumes the bullet's `hit`, `BulletX` and `BulletY`.

---
 rtl/tank_game_pkg.sv | 45 ++++
 rtl/key_edge.sv | 47 ++++
 rtl/turn_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_turn_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tank_game_pkg
// Purpose  : Shared types and constants for the two-tank artillery game.
//            Turn state encoding, facing directions, hit-point width and
//            small helpers used by the turn sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package tank_game_pkg;

  localparam int HP_W = 4;

  typedef enum logic [2:0] {
    AIM    = 3'd0,
    FIRE   = 3'd1,
    FLIGHT = 3'd2,
    SETTLE = 3'd3,
    OVER   = 3'd4
  } turn_state_t;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;

  // Bit positions of the keys inside the packed key vector.
  localparam int KEY_N     = 5;
  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_DOWN  = 3;
  localparam int KEY_FIRE  = 4;

  // Player 0 starts on the left of the field and faces right; player 1 the
  // opposite.
  function automatic logic [1:0] default_dir(input logic tank);
    return tank ? DIR_LEFT : DIR_RIGHT;
  endfunction

  // Launch velocity is upward, i.e. the negated power in 10-bit two's
  // complement.
  function automatic logic [9:0] neg_power(input logic [3:0] power);
    return 10'd0 - {6'd0, power};
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_edge.sv
`default_nettype none
// ============================================================================
// Module   : key_edge
// Purpose  : Per-frame key register with rising-edge detection.
// Ports    : frame_clk  - frame clock
//            Reset      - asynchronous, active-high
//            key[W]     - level key states
//            rise[W]    - one-frame pulse on each 0->1 key transition
// Revision : 1.0 - initial release
// ============================================================================
module key_edge #(
  parameter int WIDTH = 5
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] key_q;
  logic [WIDTH-1:0] key_d;
  logic             armed_q;
  logic             armed_d;

  always_comb begin
    key_d   = key;
    armed_d = 1'b1;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      key_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      key_q   <= key_d;
      armed_q <= armed_d;
    end
  end

  // The history register comes out of reset at zero, so a key already held
  // while reset is released would look like a fresh press. Edges are masked
  // for the first frame after reset so that such a key must be released and
  // pressed again.
  assign rise = key & ~key_q & {WIDTH{armed_q}};

endmodule
`default_nettype wire

// File: rtl/turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : turn_ctrl
// Purpose  : Turn and fire sequencer for the two-tank artillery game. Lets the
//            active player aim and set power, launches the bullet, watches the
//            flight, applies damage and passes the turn.
// Ports    : frame_clk, Reset                 - frame clock, async reset
//            key_left/right/up/down/fire      - level key states
//            hit, BulletX, BulletY            - bullet block feedback
//            TankX, TankY                     - active tank position
//            shoot, Direction, y_component,
//            currentTank                      - bullet block controls
//            hp0, hp1, game_over, winner,
//            state_o                          - game status / HUD
// Revision : 1.0 - initial release
// ============================================================================
module turn_ctrl
  import tank_game_pkg::*;
#(
  parameter int HP_INIT        = 5,
  parameter int POWER_MIN      = 2,
  parameter int POWER_MAX      = 15,
  parameter int POWER_INIT     = 8,
  parameter int FLIGHT_TIMEOUT = 240,
  parameter int SETTLE_FRAMES  = 30
) (
  input  logic            frame_clk,
  input  logic            Reset,
  input  logic            key_left,
  input  logic            key_right,
  input  logic            key_up,
  input  logic            key_down,
  input  logic            key_fire,
  input  logic            hit,
  input  logic [9:0]      BulletX,
  input  logic [9:0]      BulletY,
  input  logic [9:0]      TankX,
  input  logic [9:0]      TankY,
  output logic            shoot,
  output logic [1:0]      Direction,
  output logic [9:0]      y_component,
  output logic [1:0]      currentTank,
  output logic [HP_W-1:0] hp0,
  output logic [HP_W-1:0] hp1,
  output logic            game_over,
  output logic            winner,
  output logic [2:0]      state_o
);

  localparam int CNT_W = $clog2(FLIGHT_TIMEOUT + 1);
  localparam int SET_W = $clog2(SETTLE_FRAMES + 1);

  localparam logic [3:0]      P_MIN       = 4'(POWER_MIN);
  localparam logic [3:0]      P_MAX       = 4'(POWER_MAX);
  localparam logic [3:0]      P_INIT      = 4'(POWER_INIT);
  localparam logic [HP_W-1:0] HP_RST      = HP_W'(HP_INIT);
  localparam logic [CNT_W-1:0] FLIGHT_LAST = CNT_W'(FLIGHT_TIMEOUT);
  localparam logic [CNT_W-1:0] FLIGHT_MIN  = CNT_W'(2);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_FRAMES - 1);

  // Offset from the tank origin to the barrel tip, where an idle bullet is
  // parked by the bullet block.
  localparam logic [9:0] CARRY_DX = 10'd35;
  localparam logic [9:0] CARRY_DY = 10'd15;

  // --------------------------------------------------------------------------
  // Key edges
  // --------------------------------------------------------------------------
  logic [KEY_N-1:0] key_vec;
  logic [KEY_N-1:0] key_rise;

  assign key_vec = {key_fire, key_down, key_up, key_right, key_left};

  key_edge #(.WIDTH(KEY_N)) u_key_edge (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .key       (key_vec),
    .rise      (key_rise)
  );

  logic rise_left, rise_right, rise_up, rise_down, rise_fire;
  assign rise_left  = key_rise[KEY_LEFT];
  assign rise_right = key_rise[KEY_RIGHT];
  assign rise_up    = key_rise[KEY_UP];
  assign rise_down  = key_rise[KEY_DOWN];
  assign rise_fire  = key_rise[KEY_FIRE];

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  turn_state_t      state_q, state_d;
  logic             shoot_q, shoot_d;
  logic [1:0]       dir_q, dir_d;
  logic [3:0]       power_q, power_d;
  logic [9:0]       y_q, y_d;
  logic [1:0]       cur_q, cur_d;
  logic [HP_W-1:0]  hp0_q, hp0_d;
  logic [HP_W-1:0]  hp1_q, hp1_d;
  logic             over_q, over_d;
  logic             winner_q, winner_d;
  logic [CNT_W-1:0] flight_cnt_q, flight_cnt_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= AIM;
      shoot_q      <= 1'b0;
      dir_q        <= DIR_RIGHT;
      power_q      <= P_INIT;
      y_q          <= neg_power(P_INIT);
      cur_q        <= 2'd0;
      hp0_q        <= HP_RST;
      hp1_q        <= HP_RST;
      over_q       <= 1'b0;
      winner_q     <= 1'b0;
      flight_cnt_q <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      shoot_q      <= shoot_d;
      dir_q        <= dir_d;
      power_q      <= power_d;
      y_q          <= y_d;
      cur_q        <= cur_d;
      hp0_q        <= hp0_d;
      hp1_q        <= hp1_d;
      over_q       <= over_d;
      winner_q     <= winner_d;
      flight_cnt_q <= flight_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Shared conditions
  // --------------------------------------------------------------------------
  logic [HP_W-1:0] enemy_hp;
  logic            at_carry;
  logic            flight_done;
  logic            settle_done;

  assign enemy_hp = cur_q[0] ? hp0_q : hp1_q;

  // At launch the bullet still sits at the carry point, so a match is only
  // treated as "returned" once the flight has run for a couple of frames.
  assign at_carry = (flight_cnt_q >= FLIGHT_MIN) &&
                    (BulletX == TankX + CARRY_DX) &&
                    (BulletY == TankY + CARRY_DY);

  assign flight_done = hit || at_carry || (flight_cnt_q == FLIGHT_LAST);
  assign settle_done = (settle_cnt_q == SETTLE_LAST);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      AIM:     if (rise_fire) state_d = FIRE;
      FIRE:    state_d = FLIGHT;
      FLIGHT:  if (flight_done) state_d = SETTLE;
      SETTLE:  if (settle_done) state_d = (enemy_hp == '0) ? OVER : AIM;
      OVER:    if (rise_fire) state_d = AIM;
      default: state_d = AIM;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    shoot_d      = 1'b0;
    dir_d        = dir_q;
    power_d      = power_q;
    cur_d        = cur_q;
    hp0_d        = hp0_q;
    hp1_d        = hp1_q;
    over_d       = over_q;
    winner_d     = winner_q;
    flight_cnt_d = flight_cnt_q;
    settle_cnt_d = settle_cnt_q;

    case (state_q)
      AIM: begin
        // Opposing presses in the same frame cancel.
        if (rise_up && !rise_down && (power_q < P_MAX)) power_d = power_q + 4'd1;
        if (rise_down && !rise_up && (power_q > P_MIN)) power_d = power_q - 4'd1;
        if (rise_left && !rise_right) dir_d = DIR_LEFT;
        if (rise_right && !rise_left) dir_d = DIR_RIGHT;
      end
      FIRE: begin
        shoot_d      = 1'b1;
        flight_cnt_d = '0;
      end
      FLIGHT: begin
        if (flight_cnt_q != FLIGHT_LAST) flight_cnt_d = flight_cnt_q + 1'b1;
        if (flight_done) settle_cnt_d = '0;
        // Hit has top priority; damage goes to the tank that is not shooting.
        if (hit) begin
          if (cur_q[0]) begin
            if (hp0_q != '0) hp0_d = hp0_q - 1'b1;
          end else begin
            if (hp1_q != '0) hp1_d = hp1_q - 1'b1;
          end
        end
      end
      SETTLE: begin
        if (settle_done) begin
          if (enemy_hp == '0) begin
            over_d   = 1'b1;
            winner_d = cur_q[0];
          end else begin
            cur_d   = {1'b0, ~cur_q[0]};
            power_d = P_INIT;
            dir_d   = default_dir(~cur_q[0]);
          end
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      OVER: begin
        if (rise_fire) begin
          hp0_d   = HP_RST;
          hp1_d   = HP_RST;
          cur_d   = 2'd0;
          dir_d   = DIR_RIGHT;
          power_d = P_INIT;
          over_d  = 1'b0;
        end
      end
      default: ;
    endcase

    y_d = neg_power(power_d);
  end

  assign shoot       = shoot_q;
  assign Direction   = dir_q;
  assign y_component = y_q;
  assign currentTank = cur_q;
  assign hp0         = hp0_q;
  assign hp1         = hp1_q;
  assign game_over   = over_q;
  assign winner      = winner_q;
  assign state_o     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_turn_ctrl
// Purpose  : Self-checking bench for turn_ctrl. A reference model predicts the
//            game status at the end of every turn; predictions are queued when
//            the flight-ending stimulus is driven and compared once SETTLE ends.
// Revision : 1.0 - initial release
// ============================================================================
module tb_turn_ctrl;
  import tank_game_pkg::*;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [4:0] keys;
  logic       hit;
  logic [9:0] BulletX, BulletY, TankX, TankY;
  logic       shoot;
  logic [1:0] Direction;
  logic [9:0] y_component;
  logic [1:0] currentTank;
  logic [3:0] hp0, hp1;
  logic       game_over, winner;
  logic [2:0] state_o;

  turn_ctrl dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .key_left    (keys[0]),
    .key_right   (keys[1]),
    .key_up      (keys[2]),
    .key_down    (keys[3]),
    .key_fire    (keys[4]),
    .hit         (hit),
    .BulletX     (BulletX),
    .BulletY     (BulletY),
    .TankX       (TankX),
    .TankY       (TankY),
    .shoot       (shoot),
    .Direction   (Direction),
    .y_component (y_component),
    .currentTank (currentTank),
    .hp0         (hp0),
    .hp1         (hp1),
    .game_over   (game_over),
    .winner      (winner),
    .state_o     (state_o)
  );

  always #5 frame_clk = ~frame_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] hp0, hp1;
    logic [1:0] cur, dir;
    logic [9:0] y;
    logic       go, win;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];

  // Reference model of the game status.
  int         m_power = 8;
  logic [1:0] m_dir   = 2'b01;
  logic [1:0] m_cur   = 2'd0;
  int         m_hp0   = 5;
  int         m_hp1   = 5;
  logic       m_go    = 1'b0;
  logic       m_win   = 1'b0;

  function automatic logic [9:0] yval(input int p);
    return 10'(-p);
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic press(input int k);
    keys[k] = 1'b1;
    tick();
    keys[k] = 1'b0;
    tick();
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_hp0"}, hp0, 32'(m_hp0));
    check_eq({tag, "_hp1"}, hp1, 32'(m_hp1));
    check_eq({tag, "_cur"}, currentTank, m_cur);
    check_eq({tag, "_dir"}, Direction, m_dir);
    check_eq({tag, "_y"}, y_component, yval(m_power));
  endtask

  // Update the model for a flight that ends (with or without a hit) and queue
  // the status expected once SETTLE is over.
  task automatic push_exp(input bit is_hit);
    exp_t e;
    int   enemy;
    if (is_hit) begin
      if (m_cur == 2'd0) m_hp1 = (m_hp1 > 0) ? m_hp1 - 1 : 0;
      else               m_hp0 = (m_hp0 > 0) ? m_hp0 - 1 : 0;
    end
    enemy = (m_cur == 2'd0) ? m_hp1 : m_hp0;
    if (enemy == 0) begin
      m_go  = 1'b1;
      m_win = m_cur[0];
      e.st  = OVER;
    end else begin
      m_cur   = m_cur ^ 2'd1;
      m_power = 8;
      m_dir   = (m_cur == 2'd0) ? 2'b01 : 2'b00;
      e.st    = AIM;
    end
    e.hp0 = 4'(m_hp0); e.hp1 = 4'(m_hp1);
    e.cur = m_cur;     e.dir = m_dir;
    e.y   = yval(m_power);
    e.go  = m_go;      e.win = m_win;
    sb.push_back(e);
  endtask

  // Press fire from AIM; ends with FLIGHT just entered (flight count 0).
  task automatic fire_turn(input string tag);
    keys[4] = 1'b1;
    tick();
    keys[4] = 1'b0;
    check_eq({tag, "_fire_state"}, state_o, FIRE);
    check_eq({tag, "_fire_shoot"}, shoot, 1'b0);
    tick();
    check_eq({tag, "_shoot_hi"}, shoot, 1'b1);
    check_eq({tag, "_flight"}, state_o, FLIGHT);
    check_eq({tag, "_launch_y"}, y_component, yval(m_power));
    check_eq({tag, "_launch_dir"}, Direction, m_dir);
    check_eq({tag, "_launch_cur"}, currentTank, m_cur);
  endtask

  // Let n more flight frames pass, then end the flight with hit and/or a
  // return to the carry point.
  task automatic fly(input string tag, input int n, input bit do_hit, input bit do_match);
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) begin
        check_eq({tag, "_shoot_lo"}, shoot, 1'b0);
        check_eq({tag, "_y_held"}, y_component, yval(m_power));
      end
      if (state_o != FLIGHT) begin
        check_eq({tag, "_early_exit"}, state_o, FLIGHT);
        return;
      end
    end
    hit = do_hit;
    if (do_match) begin
      BulletX = TankX + 10'd35;
      BulletY = TankY + 10'd15;
    end
    push_exp(do_hit);
    tick();
    hit = 1'b0; BulletX = 10'd0; BulletY = 10'd0;
    check_eq({tag, "_settle"}, state_o, SETTLE);
    check_eq({tag, "_hp0_exit"}, hp0, 32'(m_hp0));
    check_eq({tag, "_hp1_exit"}, hp1, 32'(m_hp1));
  endtask

  task automatic settle_wait(input string tag);
    int   k = 0;
    exp_t e;
    while (state_o == SETTLE && k < 100) begin
      tick();
      k++;
    end
    check_eq({tag, "_settle_len"}, k, 30);
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check_eq({tag, "_st"}, state_o, e.st);
    check_eq({tag, "_hp0"}, hp0, e.hp0);
    check_eq({tag, "_hp1"}, hp1, e.hp1);
    check_eq({tag, "_cur"}, currentTank, e.cur);
    check_eq({tag, "_dir"}, Direction, e.dir);
    check_eq({tag, "_y"}, y_component, e.y);
    check_eq({tag, "_go"}, game_over, e.go);
    check_eq({tag, "_win"}, winner, e.win);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_state"}, state_o, AIM);
    check_eq({tag, "_shoot"}, shoot, 1'b0);
    check_eq({tag, "_dir"}, Direction, 2'b01);
    check_eq({tag, "_y"}, y_component, 10'h3F8);
    check_eq({tag, "_cur"}, currentTank, 2'd0);
    check_eq({tag, "_hp0"}, hp0, 4'd5);
    check_eq({tag, "_hp1"}, hp1, 4'd5);
    check_eq({tag, "_go"}, game_over, 1'b0);
    check_eq({tag, "_win"}, winner, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    Reset = 1'b1; keys = '0; hit = 1'b0;
    BulletX = 10'd0; BulletY = 10'd0; TankX = 10'd100; TankY = 10'd200;
    #23;
    check_reset_vals("rst");
    @(negedge frame_clk);
    Reset = 1'b0;

    // Turn 1: player 0 fires at frame 3, hits at flight count 12.
    tick(); tick();
    fire_turn("t1");
    fly("t1", 12, 1'b1, 1'b0);
    settle_wait("t1");

    // Player 1 aims: held key counts once, hit in AIM ignored, clamps.
    keys[2] = 1'b1; hit = 1'b1;
    tick(); tick(); tick();
    keys[2] = 1'b0; hit = 1'b0;
    tick();
    m_power = 9;
    check_eq("held_up_y", y_component, yval(m_power));
    check_eq("aim_hit_hp0", hp0, 32'(m_hp0));
    for (int i = 0; i < 10; i++) begin
      press(2);
      m_power = (m_power < 15) ? m_power + 1 : 15;
    end
    check_eq("clamp_hi_y", y_component, 10'h3F1);
    for (int i = 0; i < 20; i++) begin
      press(3);
      m_power = (m_power > 2) ? m_power - 1 : 2;
    end
    check_eq("clamp_lo_y", y_component, 10'h3FE);
    press(1); m_dir = 2'b01;
    check_eq("dir_right", Direction, m_dir);
    keys[0] = 1'b1; keys[1] = 1'b1; tick(); keys = '0; tick();
    check_eq("dir_both", Direction, m_dir);
    press(0); m_dir = 2'b00;
    check_eq("dir_left", Direction, m_dir);

    // Turn 2: carry point present from launch must not end the flight; keys
    // in flight are ignored; return at flight count 20.
    fire_turn("t2");
    BulletX = TankX + 10'd35; BulletY = TankY + 10'd15; keys[2] = 1'b1;
    tick(); tick();
    check_eq("min_flight", state_o, FLIGHT);
    BulletX = 10'd0; BulletY = 10'd0; keys[2] = 1'b0;
    fly("t2", 18, 1'b0, 1'b1);
    settle_wait("t2");

    // Turn 3: player 0, no return, timeout at flight count 240.
    fire_turn("t3");
    push_exp(1'b0);
    k = 0;
    while (state_o == FLIGHT && k < 300) begin
      tick();
      k++;
    end
    check_eq("timeout_len", k, 241);
    settle_wait("t3");

    // Turn 4: player 1, hit and carry match in the same frame.
    fire_turn("t4");
    fly("t4", 5, 1'b1, 1'b1);
    settle_wait("t4");

    // Player 0 hits until player 1 is out; player 1 returns in between.
    for (int i = 0; i < 4; i++) begin
      fire_turn("p0");
      fly("p0", 3, 1'b1, 1'b0);
      settle_wait("p0");
      if (i < 3) begin
        fire_turn("p1");
        fly("p1", 2, 1'b0, 1'b1);
        settle_wait("p1");
      end
    end
    check_eq("over_go", game_over, 1'b1);
    check_eq("over_win", winner, 1'b0);
    check_eq("over_hp1", hp1, 4'd0);

    // Frozen in OVER: direction/power keys do nothing.
    press(2); press(0);
    check_eq("frozen_state", state_o, OVER);
    check_status("frozen");

    // Fire edge restarts the game.
    press(4);
    m_hp0 = 5; m_hp1 = 5; m_cur = 2'd0; m_dir = 2'b01; m_power = 8; m_go = 1'b0;
    check_eq("restart_state", state_o, AIM);
    check_eq("restart_go", game_over, 1'b0);
    check_status("restart");

    // Reset in mid-flight with fire held across the release.
    fire_turn("t9");
    tick(); tick();
    #2;
    keys[4] = 1'b1;
    Reset   = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge frame_clk);
    Reset = 1'b0;
    tick(); tick(); tick();
    check_eq("held_fire_state", state_o, AIM);
    check_eq("held_fire_shoot", shoot, 1'b0);
    keys[4] = 1'b0;
    tick();
    keys[4] = 1'b1;
    tick();
    keys[4] = 1'b0;
    check_eq("refire_state", state_o, FIRE);
    tick();
    check_eq("refire_shoot", shoot, 1'b1);

    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
